// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width helper and Gray encode/decode shared by the FIFO controllers.
package fifo_pkg;

   localparam int MAX_W = 32;

   function automatic int ptr_w(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b = '0;
      for (int i = 0; i < MAX_W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a Gray-coded bus crossing into clk's domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] rq1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq1 <= '0;
         q   <= '0;
      end else begin
         rq1 <= d;
         q   <= rq1;
      end
   end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side CDC FIFO controller with binary/Gray write pointer,
// synchronised read pointer, registered full flag and conservative occupancy.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
   output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   level_o
);

   localparam int PW = ptr_w(ADDR_WIDTH);

   logic [PW-1:0] wr_bin, wr_bin_next, wr_gray_next, rq2, rd_bin_sync;
   logic          full_next;

   sync_2ff #(.WIDTH(PW)) u_rd_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rd_ptr_gray_i),
      .q     (rq2)
   );

   assign wr_ready_o = ~full_o;
   assign wr_addr_o  = wr_bin[ADDR_WIDTH-1:0];

   // Full when the next write pointer sits exactly one lap ahead of the synced read pointer.
   always_comb begin
      wr_en_o      = wr_valid_i & ~full_o;
      wr_bin_next  = wr_bin + PW'(wr_en_o);
      wr_gray_next = PW'(bin2gray(MAX_W'(wr_bin_next)));
      rd_bin_sync  = '0;
      for (int i = 0; i < PW; i++) rd_bin_sync[i] = ^(rq2 >> i);
      full_next    = wr_gray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bin        <= '0;
         wr_ptr_gray_o <= '0;
         full_o        <= 1'b0;
         level_o       <= '0;
      end else begin
         wr_bin        <= wr_bin_next;
         wr_ptr_gray_o <= wr_gray_next;
         full_o        <= full_next;
         level_o       <= wr_bin_next - rd_bin_sync;
      end
   end

endmodule
